// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : key_debouncer
//  Description : Multi-channel push-button debouncer. Each active-low raw key
//                is synchronised, inverted to active-high and filtered by a
//                four-state FSM. The FSM produces a registered debounced
//                level, press/release strobes and a one-shot long-press
//                strobe.
//  Ports       :
//     clk             - system clock, rising edge
//     resetN          - asynchronous active-low reset
//     keyN            - raw keys, asynchronous, active-low (0 = pressed)
//     keyIsPressed    - debounced level, 1 while the key is accepted as pressed
//     keyPressPulse   - one-cycle strobe on an accepted press
//     keyReleasePulse - one-cycle strobe on an accepted release
//     keyLongPress    - one-cycle strobe once the key is held LONG_PRESS_CYCLES
//  Revision    : 1.0  initial release
// ============================================================================
module key_debouncer #(
   parameter int NUM_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES   = 500000,
   parameter int LONG_PRESS_CYCLES = 50000000
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic [NUM_KEYS-1:0] keyN,
   output logic [NUM_KEYS-1:0] keyIsPressed,
   output logic [NUM_KEYS-1:0] keyPressPulse,
   output logic [NUM_KEYS-1:0] keyReleasePulse,
   output logic [NUM_KEYS-1:0] keyLongPress
);

   localparam int c_DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int c_HOLD_W = $clog2(LONG_PRESS_CYCLES) + 1;

   localparam logic [c_DEB_W-1:0]  c_DEB_ZERO  = '0;
   localparam logic [c_DEB_W-1:0]  c_DEB_ONE   = c_DEB_W'(1);
   localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_ZERO = '0;
   localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(LONG_PRESS_CYCLES);

   typedef enum logic [1:0] {
      S_RELEASED   = 2'd0,
      S_PRESS_PEND = 2'd1,
      S_PRESSED    = 2'd2,
      S_REL_PEND   = 2'd3
   } state_t;

   generate
      for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
         logic                r_sync1;
         logic                r_sync2;
         logic                w_pressed;
         state_t              r_state;
         state_t              w_state_next;
         logic [c_DEB_W-1:0]  r_deb;
         logic [c_DEB_W-1:0]  w_deb_next;
         logic [c_HOLD_W-1:0] r_hold;
         logic [c_HOLD_W-1:0] w_hold_next;
         logic                r_is_pressed;
         logic                r_press_pulse;
         logic                r_rel_pulse;
         logic                r_long;
         logic                w_is_pressed;
         logic                w_press_pulse;
         logic                w_rel_pulse;
         logic                w_long;

         // Two-flop synchroniser; resets to the released (high) level so a
         // key held through reset is debounced afresh.
         always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
               r_sync1 <= 1'b1;
               r_sync2 <= 1'b1;
            end else begin
               r_sync1 <= keyN[g];
               r_sync2 <= r_sync1;
            end
         end

         assign w_pressed = ~r_sync2;

         always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
               r_state       <= S_RELEASED;
               r_deb         <= c_DEB_ZERO;
               r_hold        <= c_HOLD_ZERO;
               r_is_pressed  <= 1'b0;
               r_press_pulse <= 1'b0;
               r_rel_pulse   <= 1'b0;
               r_long        <= 1'b0;
            end else begin
               r_state       <= w_state_next;
               r_deb         <= w_deb_next;
               r_hold        <= w_hold_next;
               r_is_pressed  <= w_is_pressed;
               r_press_pulse <= w_press_pulse;
               r_rel_pulse   <= w_rel_pulse;
               r_long        <= w_long;
            end
         end

         always_comb begin
            w_state_next = r_state;
            w_deb_next   = r_deb;
            w_hold_next  = r_hold;
            case (r_state)
               S_RELEASED: begin
                  if (w_pressed) begin
                     w_state_next = S_PRESS_PEND;
                     w_deb_next   = c_DEB_ZERO;
                  end
               end
               S_PRESS_PEND: begin
                  if (!w_pressed) begin
                     w_state_next = S_RELEASED;
                     w_deb_next   = c_DEB_ZERO;
                     w_hold_next  = c_HOLD_ZERO;
                  end else if (r_deb == c_DEB_LAST) begin
                     w_state_next = S_PRESSED;
                     w_deb_next   = c_DEB_ZERO;
                     w_hold_next  = c_HOLD_ZERO;
                  end else begin
                     w_deb_next   = r_deb + c_DEB_ONE;
                  end
               end
               S_PRESSED: begin
                  // Hold time accrues only while firmly pressed and
                  // saturates so the long-press strobe cannot repeat.
                  if (r_hold != c_HOLD_MAX) begin
                     w_hold_next = r_hold + c_HOLD_ONE;
                  end
                  if (!w_pressed) begin
                     w_state_next = S_REL_PEND;
                     w_deb_next   = c_DEB_ZERO;
                  end
               end
               S_REL_PEND: begin
                  // A pressed sample here is release bounce: return to
                  // PRESSED keeping the hold count so no event repeats.
                  if (w_pressed) begin
                     w_state_next = S_PRESSED;
                     w_deb_next   = c_DEB_ZERO;
                  end else if (r_deb == c_DEB_LAST) begin
                     w_state_next = S_RELEASED;
                     w_deb_next   = c_DEB_ZERO;
                     w_hold_next  = c_HOLD_ZERO;
                  end else begin
                     w_deb_next   = r_deb + c_DEB_ONE;
                  end
               end
               default: begin
                  w_state_next = S_RELEASED;
                  w_deb_next   = c_DEB_ZERO;
                  w_hold_next  = c_HOLD_ZERO;
               end
            endcase
         end

         // Outputs are decoded from the next state so that, once registered,
         // they line up with the state register.
         always_comb begin
            w_is_pressed  = (w_state_next == S_PRESSED) || (w_state_next == S_REL_PEND);
            w_press_pulse = (r_state == S_PRESS_PEND) && (w_state_next == S_PRESSED);
            w_rel_pulse   = (r_state == S_REL_PEND)   && (w_state_next == S_RELEASED);
            w_long        = (w_hold_next == c_HOLD_MAX) && (r_hold != c_HOLD_MAX);
         end

         assign keyIsPressed[g]    = r_is_pressed;
         assign keyPressPulse[g]   = r_press_pulse;
         assign keyReleasePulse[g] = r_rel_pulse;
         assign keyLongPress[g]    = r_long;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debouncer
//  Description : Self-checking bench for key_debouncer (DEBOUNCE_CYCLES=4,
//                LONG_PRESS_CYCLES=16, NUM_KEYS=4). A sample-run-length model
//                predicts every output cycle into a scoreboard queue; a table
//                of key segments also carries per-segment expected events.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_debouncer;
   localparam int NK   = 4;
   localparam int DEB  = 4;
   localparam int LONG = 16;

   logic          clk = 1'b0;
   logic          resetN;
   logic [NK-1:0] keyN;
   logic [NK-1:0] keyIsPressed;
   logic [NK-1:0] keyPressPulse;
   logic [NK-1:0] keyReleasePulse;
   logic [NK-1:0] keyLongPress;

   key_debouncer #(
      .NUM_KEYS          (NK),
      .DEBOUNCE_CYCLES   (DEB),
      .LONG_PRESS_CYCLES (LONG)
   ) u_dut (
      .clk             (clk),
      .resetN          (resetN),
      .keyN            (keyN),
      .keyIsPressed    (keyIsPressed),
      .keyPressPulse   (keyPressPulse),
      .keyReleasePulse (keyReleasePulse),
      .keyLongPress    (keyLongPress)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] key_n;
      int         len;
      logic [3:0] exp_lvl;
      logic [3:0] exp_pp;
      logic [3:0] exp_rp;
      logic [3:0] exp_lp;
   } vec_t;

   vec_t        tbl [17];
   int          n_vec = 0;
   int          n_bad = 0;
   logic [15:0] sb_q [$];

   logic m_last [NK];
   logic m_lvl  [NK];
   int   m_run  [NK];
   int   m_hold [NK];
   int   cnt_pp [NK];
   int   cnt_rp [NK];
   int   cnt_lp [NK];
   int   iter;
   int   first_pp0;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   // Model: the accepted level follows the synchronised sample once it has
   // been identical for DEB+1 consecutive evaluations. Hold time counts
   // evaluations made while accepted and the previous sample was pressed.
   task automatic model_init();
      for (int c = 0; c < NK; c++) begin
         m_last[c] = 1'b0;
         m_lvl[c]  = 1'b0;
         m_run[c]  = DEB + 1;
         m_hold[c] = 0;
      end
      sb_q.delete();
      sb_q.push_back(16'h0);
      sb_q.push_back(16'h0);
   endtask

   task automatic model_step(input logic [3:0] kn);
      logic [3:0] lv, pp, rp, lp;
      logic       s, in_pr;
      lv = '0; pp = '0; rp = '0; lp = '0;
      for (int c = 0; c < NK; c++) begin
         s     = ~kn[c];
         in_pr = m_lvl[c] && m_last[c];
         if (s == m_last[c]) begin
            if (m_run[c] < 1000) m_run[c]++;
         end else begin
            m_run[c]  = 1;
            m_last[c] = s;
         end
         if (in_pr && m_hold[c] < LONG) begin
            m_hold[c]++;
            if (m_hold[c] == LONG) lp[c] = 1'b1;
         end
         if (m_run[c] >= DEB + 1 && s != m_lvl[c]) begin
            m_lvl[c]  = s;
            m_hold[c] = 0;
            if (s) pp[c] = 1'b1;
            else   rp[c] = 1'b1;
         end
         lv[c] = m_lvl[c];
      end
      sb_q.push_back({lp, rp, pp, lv});
   endtask

   task automatic clear_counts();
      for (int c = 0; c < NK; c++) begin
         cnt_pp[c] = 0; cnt_rp[c] = 0; cnt_lp[c] = 0;
      end
      iter      = 0;
      first_pp0 = -1;
   endtask

   task automatic step(input logic [3:0] kn);
      logic [15:0] exp;
      keyN = kn;
      model_step(kn);
      @(negedge clk);
      exp = sb_q.pop_front();
      check("scoreboard", {keyLongPress, keyReleasePulse, keyPressPulse, keyIsPressed}, exp);
      iter++;
      for (int c = 0; c < NK; c++) begin
         if (keyPressPulse[c])   cnt_pp[c]++;
         if (keyReleasePulse[c]) cnt_rp[c]++;
         if (keyLongPress[c])    cnt_lp[c]++;
      end
      if (keyPressPulse[0] && first_pp0 < 0) first_pp0 = iter;
   endtask

   function automatic logic [7:0] enc(input int a0, input int a1, input int a2, input int a3);
      enc = {2'(a3 > 3 ? 3 : a3), 2'(a2 > 3 ? 3 : a2), 2'(a1 > 3 ? 3 : a1), 2'(a0 > 3 ? 3 : a0)};
   endfunction

   function automatic logic [7:0] spread(input logic [3:0] m);
      spread = {1'b0, m[3], 1'b0, m[2], 1'b0, m[1], 1'b0, m[0]};
   endfunction

   task automatic pulse_total(output int t);
      t = 0;
      for (int c = 0; c < NK; c++) t += cnt_pp[c] + cnt_rp[c] + cnt_lp[c];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int tot;
      tbl[0]  = '{4'hF,  8, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[1]  = '{4'hE, 30, 4'h1, 4'h1, 4'h0, 4'h1};
      tbl[2]  = '{4'hF, 10, 4'h0, 4'h0, 4'h1, 4'h0};
      tbl[3]  = '{4'hD,  3, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[4]  = '{4'hF, 10, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[5]  = '{4'hB, 10, 4'h4, 4'h4, 4'h0, 4'h0};
      tbl[6]  = '{4'hF,  2, 4'h4, 4'h0, 4'h0, 4'h0};
      tbl[7]  = '{4'hB,  1, 4'h4, 4'h0, 4'h0, 4'h0};
      tbl[8]  = '{4'hF, 10, 4'h0, 4'h0, 4'h4, 4'h0};
      tbl[9]  = '{4'h6, 10, 4'h9, 4'h9, 4'h0, 4'h0};
      tbl[10] = '{4'hF, 10, 4'h0, 4'h0, 4'h9, 4'h0};
      tbl[11] = '{4'hD, 12, 4'h2, 4'h2, 4'h0, 4'h0};
      tbl[12] = '{4'hF, 10, 4'h0, 4'h0, 4'h2, 4'h0};
      tbl[13] = '{4'hE, 26, 4'h1, 4'h1, 4'h0, 4'h1};
      tbl[14] = '{4'hF,  2, 4'h1, 4'h0, 4'h0, 4'h0};
      tbl[15] = '{4'hE, 10, 4'h1, 4'h0, 4'h0, 4'h0};
      tbl[16] = '{4'hF, 10, 4'h0, 4'h0, 4'h1, 4'h0};

      resetN = 1'b0;
      keyN   = 4'hF;
      repeat (3) @(negedge clk);
      check("reset_state", {keyLongPress, keyReleasePulse, keyPressPulse, keyIsPressed}, 16'h0);
      resetN = 1'b1;
      model_init();

      for (int i = 0; i < 17; i++) begin
         clear_counts();
         for (int j = 0; j < tbl[i].len; j++) step(tbl[i].key_n);
         check($sformatf("seg%0d_level", i), {12'h0, keyIsPressed}, {12'h0, tbl[i].exp_lvl});
         check($sformatf("seg%0d_press", i),
               {8'h0, enc(cnt_pp[0], cnt_pp[1], cnt_pp[2], cnt_pp[3])}, {8'h0, spread(tbl[i].exp_pp)});
         check($sformatf("seg%0d_release", i),
               {8'h0, enc(cnt_rp[0], cnt_rp[1], cnt_rp[2], cnt_rp[3])}, {8'h0, spread(tbl[i].exp_rp)});
         check($sformatf("seg%0d_long", i),
               {8'h0, enc(cnt_lp[0], cnt_lp[1], cnt_lp[2], cnt_lp[3])}, {8'h0, spread(tbl[i].exp_lp)});
      end

      // Reset while channel 0 is accepted and still held down.
      clear_counts();
      repeat (10) step(4'hE);
      check("held_before_reset", {12'h0, keyIsPressed}, 16'h1);
      resetN = 1'b0;
      #1;
      check("reset_async_clear", {keyLongPress, keyReleasePulse, keyPressPulse, keyIsPressed}, 16'h0);
      repeat (2) begin
         @(negedge clk);
         check("reset_hold", {keyLongPress, keyReleasePulse, keyPressPulse, keyIsPressed}, 16'h0);
      end
      resetN = 1'b1;
      model_init();
      clear_counts();
      repeat (12) step(4'hE);
      check("repress_count", 16'(cnt_pp[0]), 16'd1);
      check("repress_latency", 16'(first_pp0), 16'd7);

      // Reset in PRESS_PEND on channel 1: nothing may pulse afterwards.
      repeat (10) step(4'hF);
      repeat (4) step(4'hD);
      resetN = 1'b0;
      keyN   = 4'hF;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      model_init();
      clear_counts();
      repeat (10) step(4'hF);
      pulse_total(tot);
      check("reset_press_pend_quiet", 16'(tot), 16'd0);

      // Reset in REL_PEND on channel 2: no release pulse may appear.
      repeat (12) step(4'hB);
      clear_counts();
      repeat (4) step(4'hF);
      resetN = 1'b0;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      model_init();
      repeat (10) step(4'hF);
      pulse_total(tot);
      check("reset_rel_pend_quiet", 16'(tot), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 The module SHALL have parameter NUM_KEYS, default 4: number of independent push-button channels.
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable synchronized samples required to accept a press or release (legal range ≥2).
REQ-003 The module SHALL have parameter LONG_PRESS_CYCLES, default 50000000: cycles in PRESSED before a long-press event (legal range > DEBOUNCE_CYCLES).
REQ-004 The module SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 The module SHALL have port resetN, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The module SHALL have port keyN, input, NUM_KEYS bits: raw board keys, asynchronous, active-low (0 = pressed).
REQ-007 The module SHALL have port keyIsPressed, output, NUM_KEYS bits: debounced level, 1 while key accepted as pressed (drives the screen controller's key0IsPressed from bit 0).
REQ-008 The module SHALL have port keyPressPulse, output, NUM_KEYS bits: one-cycle strobe on accepted press.
REQ-009 The module SHALL have port keyReleasePulse, output, NUM_KEYS bits: one-cycle strobe on accepted release.
REQ-010 The module SHALL have port keyLongPress, output, NUM_KEYS bits: one-cycle strobe when held LONG_PRESS_CYCLES.

Function
REQ-011 Each keyN bit SHALL pass through a two-flop synchronizer and be inverted to active-high before any other logic sees it.
REQ-012 Each channel SHALL be fully independent: own synchronizer, FSM, debounce counter, hold counter; no cross-channel interaction.
REQ-013 Each channel FSM SHALL have states RELEASED, PRESS_PEND, PRESSED, REL_PEND.
REQ-014 RELEASED: synchronized pressed sample -> PRESS_PEND with debounce counter cleared to 0; otherwise stay.
REQ-015 PRESS_PEND: sample pressed -> counter increments; when counter reaches DEBOUNCE_CYCLES-1 with sample pressed -> PRESSED; any released sample -> RELEASED, counter cleared.
REQ-016 PRESSED: released sample -> REL_PEND, debounce counter cleared; hold counter increments each cycle in PRESSED, saturating at LONG_PRESS_CYCLES.
REQ-017 REL_PEND: mirror of PRESS_PEND with polarity inverted; success -> RELEASED, any pressed sample -> PRESSED without clearing hold counter and without pulses.
REQ-018 Outputs SHALL be registered: keyIsPressed = 1 in PRESSED and REL_PEND, else 0.
REQ-019 keyPressPulse SHALL be 1 for exactly the first cycle keyIsPressed is 1 after a RELEASED/PRESS_PEND episode.
REQ-020 keyReleasePulse SHALL be 1 for exactly the first cycle keyIsPressed is 0 after REL_PEND -> RELEASED.
REQ-021 keyLongPress SHALL pulse once, in the cycle the hold counter first reaches LONG_PRESS_CYCLES; no repeat until a debounced release and new press.
REQ-022 Hold counter SHALL clear on entry to PRESSED from PRESS_PEND and on entry to RELEASED.
REQ-023 Counter widths SHALL be $clog2 of their terminal value +1; no counter SHALL wrap.
REQ-024 Latency: stable press beginning before clock edge k SHALL raise keyIsPressed/keyPressPulse at edge k+2+DEBOUNCE_CYCLES (±1 for metastability resolution).
REQ-025 Bounce shorter than DEBOUNCE_CYCLES samples SHALL produce no output change on any output.
REQ-026 keyPressPulse and keyReleasePulse SHALL never be high in the same cycle on one channel; keyLongPress SHALL only be high while keyIsPressed is 1.

Reset
REQ-027 On resetN low, asynchronously: synchronizer flops = released, FSMs = RELEASED, all counters = 0, all outputs = 0.
REQ-028 Key held down through reset release SHALL be debounced afresh and produce one keyPressPulse REQ-024 latency after resetN rises.
REQ-029 Reset asserted mid PRESS_PEND, PRESSED, or REL_PEND SHALL produce no pulse on any output.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, NUM_KEYS=4)
REQ-030 keyN[0] 1->0 held 30 cycles -> keyIsPressed[0] rises 6 cycles later, keyPressPulse[0] high 1 cycle, keyLongPress[0] high 1 cycle 16 cycles after press accepted, no repeat.
REQ-031 keyN[1] glitch low 3 cycles then high -> all outputs for channel 1 stay 0.
REQ-032 keyN[2] pressed 10 cycles, release bounce 2 cycles high/1 low, then high -> single keyReleasePulse[2] only after 4 stable high samples; no second press pulse.
REQ-033 keyN[0] and keyN[3] pressed same cycle -> both keyPressPulse bits high in same cycle, channels 1,2 idle.
REQ-034 resetN low for 2 cycles while keyN[0] held pressed in PRESSED -> outputs 0 immediately; after release of resetN, keyPressPulse[0] reasserts once after 6 cycles.
REQ-035 keyN[1] held 12 cycles then released -> keyReleasePulse[1] once, keyLongPress[1] never asserted.
